instruction_prefetch: RTL and testbench

- Parametrised fetch front-end that replaces the single-register fetch stage with a pipelined request/response fetch and a prefetch FIFO.
- Issues sequential instruction-memory requests with multiple requests in flight, and tolerates variable memory latency.
- Buffers returned instructions with their PCs, and hands them to the decode stage over a valid/ready handshake.
- Handles jump/trap redirects by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/instruction_prefetch.sv | 151 +++++++++++++++
 tb/tb_instruction_prefetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch.sv
// instruction_prefetch: pipelined instruction fetch front-end with a prefetch FIFO.
// Issues sequential fetch requests with up to FIFO_DEPTH in flight. Returned
// instructions are buffered with their PCs. Jump/trap redirects flush the FIFO
// and drop stale in-flight responses.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel (to memory)
//   imem_rsp_valid/data             in-order fetch response (always accepted)
//   id_valid/ready, id_inst, id_pc  head instruction to decode
//   jump_valid/address              jump redirect
//   trap_valid/address              trap redirect (wins over jump)
module instruction_prefetch #(
  parameter int unsigned    XLEN       = 32,
  parameter int unsigned    ILEN       = 32,
  parameter int unsigned    FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_address,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_address
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  entry_t           fifo_q [FIFO_DEPTH];
  entry_t           fifo_d [FIFO_DEPTH];

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            credit_ok;
  logic            req_fire;
  logic            push;
  logic            pop;
  entry_t          head;

  // Redirect decode: trap wins, target forced to word alignment
  assign redirect = jump_valid | trap_valid;
  assign target   = (trap_valid ? trap_address : jump_address) & ~XLEN'(3);

  // In-flight plus buffered never exceeds depth; a same-cycle pop earns no credit
  assign credit_ok = (SUM_W'(outstanding_q) + SUM_W'(count_q)) < SUM_W'(FIFO_DEPTH);

  assign imem_req_valid = rst_n & ~redirect & credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses landing while discard is non-zero belong to a flushed stream
  assign push = imem_rsp_valid & ~redirect & (discard_q == '0);
  assign pop  = id_valid & id_ready & ~redirect;

  assign head     = fifo_q[rd_ptr_q];
  assign id_valid = (count_q != '0);
  assign id_inst  = id_valid ? head.inst : '0;
  assign id_pc    = id_valid ? head.pc   : '0;

  // Next-state computation for fetch PC, counters and FIFO
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_d        = fifo_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    if (imem_rsp_valid && !redirect && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end

    if (push) begin
      fifo_d[wr_ptr_q] = '{inst: imem_rsp_data, pc: rsp_pc_q};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      rsp_pc_d         = rsp_pc_q + XLEN'(4);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Everything still in flight after this cycle is stale, including this cycle's response
    if (redirect) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      discard_d  = outstanding_d;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_q        <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_q        <= fifo_d;
    end
  end

  // Credit scheme guarantees neither of these can happen
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CNT_W'(FIFO_DEPTH))));
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_instruction_prefetch.sv
// tb_instruction_prefetch: self-checking bench for instruction_prefetch.
// A behavioural memory answers accepted requests after a programmable latency;
// a scoreboard of expected {pc, inst} is filled as responses are driven and
// drained when decode consumes. Directed scenarios plus a randomised phase.
module tb_instruction_prefetch;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b1;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [ILEN-1:0] imem_rsp_data = '0;
  logic            id_valid;
  logic            id_ready = 1'b1;
  logic [ILEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic            jump_valid = 1'b0;
  logic [XLEN-1:0] jump_address = '0;
  logic            trap_valid = 1'b0;
  logic [XLEN-1:0] trap_address = '0;

  always #5 clk = ~clk;

  instruction_prefetch #(
    .XLEN(XLEN), .ILEN(ILEN), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .jump_valid(jump_valid), .jump_address(jump_address),
    .trap_valid(trap_valid), .trap_address(trap_address)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory content is a fixed function of the address
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  typedef struct { logic [31:0] addr; int unsigned due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  req_t        pend[$];
  exp_t        sb[$];
  logic [31:0] exp_req_pc = RPC;
  logic [31:0] exp_rsp_pc = RPC;
  int unsigned disc_m = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned pops = 0;
  int unsigned issued = 0;

  // Memory model and scoreboard; evaluates the upcoming rising edge
  always @(negedge clk) begin : mon
    logic        redir;
    logic        fire;
    logic        rsp;
    logic [31:0] rsp_addr;
    logic [31:0] tgt;
    int unsigned out_m;
    if (!rst_n) begin
      pend.delete();
      sb.delete();
      exp_req_pc     = RPC;
      exp_rsp_pc     = RPC;
      disc_m         = 0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else begin
      cyc++;
      out_m    = pend.size();
      rsp      = 1'b0;
      rsp_addr = '0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        rsp      = 1'b1;
        rsp_addr = pend[0].addr;
        void'(pend.pop_front());
      end
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? inst_of(rsp_addr) : '0;

      redir = jump_valid || trap_valid;
      check("req_valid", 64'(imem_req_valid),
            64'(!redir && ((out_m + sb.size()) < DEPTH)));
      if (imem_req_valid) check("req_addr", 64'(imem_req_addr), 64'(exp_req_pc));
      fire = imem_req_valid && imem_req_ready;
      if (fire) begin
        pend.push_back('{addr: imem_req_addr, due: cyc + lat});
        exp_req_pc += 32'd4;
        issued++;
      end

      check("id_valid", 64'(id_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("id_pc", 64'(id_pc), 64'(sb[0].pc));
        check("id_inst", 64'(id_inst), 64'(sb[0].inst));
      end else begin
        check("id_idle", {id_pc, id_inst}, 64'h0);
      end
      if (id_valid && id_ready && !redir && sb.size() != 0) begin
        void'(sb.pop_front());
        pops++;
      end

      if (rsp && !redir) begin
        if (disc_m > 0) disc_m--;
        else begin
          sb.push_back('{pc: exp_rsp_pc, inst: inst_of(exp_rsp_pc)});
          exp_rsp_pc += 32'd4;
        end
      end

      if (redir) begin
        tgt        = trap_valid ? trap_address : jump_address;
        tgt[1:0]   = 2'b00;
        sb.delete();
        disc_m     = pend.size();
        exp_req_pc = tgt;
        exp_rsp_pc = tgt;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'h0);
    check("rst_id_valid", 64'(id_valid), 64'h0);
    check("rst_id", {id_pc, id_inst}, 64'h0);
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50 && !id_valid; i++) step(1);
    check(tag, 64'(id_valid), 64'h1);
  endtask

  task automatic redirect(input logic j, input logic [31:0] ja,
                          input logic t, input logic [31:0] ta);
    jump_valid = j; jump_address = ja;
    trap_valid = t; trap_address = ta;
    step(1);
    jump_valid = 1'b0;
    trap_valid = 1'b0;
  endtask

  int unsigned p0;
  int unsigned i0;

  initial begin
    // Streaming with 1-cycle memory
    lat = 1;
    do_reset();
    step(1);
    check("t1_c1_idle", 64'(id_valid), 64'h0);
    step(1);
    check("t1_c2_valid", 64'(id_valid), 64'h1);
    check("t1_c2_pc", 64'(id_pc), 64'h0);
    step(1);
    check("t1_c3_pc", 64'(id_pc), 64'h4);
    p0 = pops;
    step(20);
    check("t1_rate", 64'(pops - p0), 64'd20);

    // Decode stall: credit limits requests to the FIFO depth
    do_reset();
    id_ready = 1'b0;
    i0 = issued;
    step(15);
    check("t2_issued", 64'(issued - i0), 64'd4);
    check("t2_req_idle", 64'(imem_req_valid), 64'h0);
    check("t2_head_pc", 64'(id_pc), 64'h0);
    check("t2_head_inst", 64'(id_inst), 64'(inst_of(32'h0)));
    id_ready = 1'b1;
    step(1);
    check("t2_resume_valid", 64'(imem_req_valid), 64'h1);
    check("t2_resume_addr", 64'(imem_req_addr), 64'h10);
    step(12);

    // Jump with three stale responses in flight
    lat = 3;
    do_reset();
    step(3);
    redirect(1'b1, 32'h103, 1'b0, 32'h0);
    check("t3_flushed", 64'(id_valid), 64'h0);
    wait_valid("t3_timeout");
    check("t3_pc", 64'(id_pc), 64'h100);
    check("t3_inst", 64'(id_inst), 64'(inst_of(32'h100)));

    // Simultaneous jump and trap: trap wins
    lat = 1;
    do_reset();
    step(5);
    redirect(1'b1, 32'h200, 1'b1, 32'h80);
    wait_valid("t4_timeout");
    check("t4_pc", 64'(id_pc), 64'h80);

    // Redirect during a busy stream, then back-to-back redirects
    step(5);
    redirect(1'b1, 32'h300, 1'b0, 32'h0);
    redirect(1'b0, 32'h0, 1'b1, 32'h405);
    wait_valid("t5_timeout");
    check("t5_pc", 64'(id_pc), 64'h404);
    step(6);

    // Reset pulse with requests outstanding
    lat = 2;
    step(4);
    lat = 1;
    do_reset();
    step(1);
    check("t6_c1_idle", 64'(id_valid), 64'h0);
    step(1);
    check("t6_restart_pc", 64'(id_pc), 64'(RPC));

    // Randomised backpressure, latency and redirects
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      id_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 24) == 0) begin
        jump_valid   = ($urandom_range(0, 1) != 0);
        trap_valid   = !jump_valid || ($urandom_range(0, 1) != 0);
        jump_address = $urandom;
        trap_address = $urandom;
      end
      step(1);
      jump_valid = 1'b0;
      trap_valid = 1'b0;
    end
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    step(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
